// File: rtl/joybus_tx_frame.sv
// Joybus frame transmitter: 1..MAX_BYTES bytes via a one-byte holding buffer, then a console or controller stop bit.
// Define JBTX_CRC_EN to append a CRC-8 (poly 0x85) byte after the payload.
module joybus_tx_frame #(
    parameter int QUART_CYC     = 50,
    parameter int MAX_BYTES     = 36,
    parameter int STOP_HOLD_CYC = 100,
    parameter int LEN_W         = $clog2(MAX_BYTES + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             stop_long,
    input  logic [7:0]       byte_data,
    input  logic             byte_vld,
    output logic             byte_rdy,
    output logic             jb_tx,
    output logic             jb_oe,
    output logic             busy,
    output logic             done,
    output logic             underrun
);

    localparam int CNT_SPAN = (2 * QUART_CYC > STOP_HOLD_CYC) ? 2 * QUART_CYC : STOP_HOLD_CYC;
    localparam int CNT_W    = $clog2(CNT_SPAN);

    localparam logic [CNT_W-1:0] Q_LD    = CNT_W'(QUART_CYC - 1);
    localparam logic [CNT_W-1:0] Q2_LD   = CNT_W'(2 * QUART_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LD = CNT_W'(STOP_HOLD_CYC - 1);
    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_BYTES);

    typedef enum logic [2:0] {IDLE, FETCH, BIT, STOP_LOW, STOP_HOLD} state_t;
    typedef enum logic [1:0] {SEG_LOW, SEG_DATA, SEG_HIGH} seg_t;

    state_t           state;
    seg_t             seg;
    logic [2:0]       bit_idx;
    logic [CNT_W-1:0] cnt;
    logic [7:0]       shreg;
    logic [7:0]       hold_byte;
    logic             hold_full;
    logic [LEN_W-1:0] fetch_left;
    logic             stop_long_r;

    logic             hs;
    logic             accept;
    logic             last_cell;
    logic [LEN_W-1:0] len_clamped;
    logic [7:0]       crc;
    logic             crc_pend;

    assign hs          = byte_vld & byte_rdy;
    assign accept      = (state == IDLE) && start && (len != '0);
    assign last_cell   = (state == BIT) && (seg == SEG_HIGH) && (cnt == '0) && (bit_idx == 3'd7);
    assign len_clamped = (len > MAX_LEN) ? MAX_LEN : len;

`ifdef JBTX_CRC_EN
    logic       ld_payload;
    logic [7:0] ld_byte;

    function automatic logic [7:0] crc8_byte(input logic [7:0] c, input logic [7:0] d);
        logic [7:0] r;
        r = c ^ d;
        for (int i = 0; i < 8; i++)
            r = r[7] ? ((r << 1) ^ 8'h85) : (r << 1);
        return r;
    endfunction

    // The CRC follows every payload byte as it enters the shift register.
    assign ld_payload = ((state == FETCH) && hs) ||
                        (last_cell && (hold_full || ((fetch_left != '0) && hs)));
    assign ld_byte    = (last_cell && hold_full) ? hold_byte : byte_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            crc      <= 8'h00;
            crc_pend <= 1'b0;
        end else if (accept) begin
            crc      <= 8'h00;
            crc_pend <= 1'b1;
        end else if (ld_payload) begin
            crc      <= crc8_byte(crc, ld_byte);
        end else if (last_cell && crc_pend) begin
            crc_pend <= 1'b0;
        end
    end
`else
    assign crc      = 8'h00;
    assign crc_pend = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            seg         <= SEG_LOW;
            bit_idx     <= 3'd0;
            cnt         <= '0;
            shreg       <= 8'h00;
            hold_byte   <= 8'h00;
            hold_full   <= 1'b0;
            fetch_left  <= '0;
            stop_long_r <= 1'b0;
            jb_tx       <= 1'b1;
            jb_oe       <= 1'b0;
            byte_rdy    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            underrun    <= 1'b0;
        end else begin
            done     <= 1'b0;
            underrun <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        fetch_left  <= len_clamped;
                        stop_long_r <= stop_long;
                        hold_full   <= 1'b0;
                        busy        <= 1'b1;
                        byte_rdy    <= 1'b1;
                        state       <= FETCH;
                    end
                end
                FETCH: begin
                    if (hs) begin
                        shreg      <= byte_data;
                        fetch_left <= fetch_left - 1'b1;
                        byte_rdy   <= (fetch_left != LEN_W'(1));
                        seg        <= SEG_LOW;
                        bit_idx    <= 3'd0;
                        cnt        <= Q_LD;
                        jb_oe      <= 1'b1;
                        jb_tx      <= 1'b0;
                        state      <= BIT;
                    end
                end
                BIT: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        case (seg)
                            SEG_LOW: begin
                                seg   <= SEG_DATA;
                                cnt   <= Q2_LD;
                                jb_tx <= shreg[7];
                            end
                            SEG_DATA: begin
                                seg   <= SEG_HIGH;
                                cnt   <= Q_LD;
                                jb_tx <= 1'b1;
                            end
                            default: begin
                                seg     <= SEG_LOW;
                                cnt     <= Q_LD;
                                jb_tx   <= 1'b0;
                                bit_idx <= bit_idx + 3'd1;
                                shreg   <= shreg << 1;
                                if (bit_idx == 3'd7) begin
                                    if (hold_full) begin
                                        shreg     <= hold_byte;
                                        hold_full <= 1'b0;
                                        byte_rdy  <= (fetch_left != '0);
                                    end else if (fetch_left != '0) begin
                                        // A byte arriving on the boundary edge bypasses the buffer.
                                        if (hs) begin
                                            shreg      <= byte_data;
                                            fetch_left <= fetch_left - 1'b1;
                                            byte_rdy   <= (fetch_left != LEN_W'(1));
                                        end else begin
                                            underrun <= 1'b1;
                                            jb_oe    <= 1'b0;
                                            jb_tx    <= 1'b1;
                                            busy     <= 1'b0;
                                            byte_rdy <= 1'b0;
                                            state    <= IDLE;
                                        end
                                    end else if (crc_pend) begin
                                        shreg <= crc;
                                    end else begin
                                        cnt   <= stop_long_r ? Q2_LD : Q_LD;
                                        state <= STOP_LOW;
                                    end
                                end
                            end
                        endcase
                    end
                    if (hs && !last_cell) begin
                        hold_byte  <= byte_data;
                        hold_full  <= 1'b1;
                        fetch_left <= fetch_left - 1'b1;
                        byte_rdy   <= 1'b0;
                    end
                end
                STOP_LOW: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        cnt   <= HOLD_LD;
                        jb_oe <= 1'b0;
                        jb_tx <= 1'b1;
                        state <= STOP_HOLD;
                        if (STOP_HOLD_CYC == 1) begin
                            done <= 1'b1;
                            busy <= 1'b0;
                        end
                    end
                end
                STOP_HOLD: begin
                    // done and busy=0 land on the final hold cycle.
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                        if (cnt == CNT_W'(1)) begin
                            done <= 1'b1;
                            busy <= 1'b0;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_joybus_tx_frame.sv
// Bench for joybus_tx_frame: per-cycle line/handshake checks against a waveform model built from the frame bytes.
module tb_joybus_tx_frame;

    localparam int Q        = 50;
    localparam int MAXB     = 4;
    localparam int H        = 100;
    localparam int LW       = 3;
    localparam int BYTE_CYC = 32 * Q;

    localparam logic [31:0] IDLE_V  = 32'b010000;
    localparam logic [31:0] FETCH_V = 32'b011001;
`ifdef JBTX_CRC_EN
    localparam logic [31:0] T1_TOTAL = 32'd3352;
`else
    localparam logic [31:0] T1_TOTAL = 32'd1752;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [LW-1:0] len = '0;
    logic          stop_long = 1'b0;
    logic [7:0]    byte_data = 8'h00;
    logic          byte_vld = 1'b0;
    logic          byte_rdy, jb_tx, jb_oe, busy, done, underrun;

    int         compared = 0;
    int         mismatched = 0;
    logic [7:0] fbytes[MAXB];
    logic [4:0] exp_q[$];   // {oe, tx, busy, done, underrun} per cycle
    int         data_end;

    joybus_tx_frame #(.QUART_CYC(Q), .MAX_BYTES(MAXB), .STOP_HOLD_CYC(H), .LEN_W(LW)) dut (
        .clk(clk), .rst(rst), .start(start), .len(len), .stop_long(stop_long),
        .byte_data(byte_data), .byte_vld(byte_vld), .byte_rdy(byte_rdy),
        .jb_tx(jb_tx), .jb_oe(jb_oe), .busy(busy), .done(done), .underrun(underrun)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] obs_vec();
        return {26'b0, jb_oe, jb_tx, busy, done, underrun, byte_rdy};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp, output bit ok);
        compared++;
        ok = (obs === exp);
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

`ifdef JBTX_CRC_EN
    function automatic logic [7:0] ref_crc(input int nb);
        logic [7:0] c;
        logic [7:0] d;
        logic       fb;
        c = 8'h00;
        for (int k = 0; k < nb; k++) begin
            d = fbytes[k];
            for (int i = 7; i >= 0; i--) begin
                fb = c[7] ^ d[i];
                c  = {c[6:0], 1'b0};
                if (fb) c = c ^ 8'h85;
            end
        end
        return c;
    endfunction
`endif

    task automatic push_n(input logic [4:0] v, input int n);
        repeat (n) exp_q.push_back(v);
    endtask

    task automatic build_exp(input int sent, input bit urun, input bit sl);
        logic [7:0] msg[$];
        logic [7:0] b;
        exp_q.delete();
        for (int k = 0; k < sent; k++) msg.push_back(fbytes[k]);
`ifdef JBTX_CRC_EN
        if (!urun) msg.push_back(ref_crc(sent));
`endif
        foreach (msg[k]) begin
            b = msg[k];
            for (int i = 7; i >= 0; i--) begin
                push_n(5'b10100, Q);
                push_n({1'b1, b[i], 3'b100}, 2 * Q);
                push_n(5'b11100, Q);
            end
        end
        data_end = exp_q.size();
        if (urun) begin
            exp_q.push_back(5'b01001);
        end else begin
            push_n(5'b10100, sl ? 2 * Q : Q);
            push_n(5'b01100, H - 1);
            exp_q.push_back(5'b01010);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; byte_vld = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Decide byte_vld for the coming edge; a handshake counts from the next cycle on.
    task automatic drive(input int n, input bit allow, input int max_gap, inout int acc, inout int gap);
        if (acc < n && allow && gap == 0) begin
            byte_vld  = 1'b1;
            byte_data = fbytes[acc];
        end else begin
            byte_vld = 1'b0;
            if (gap > 0) gap--;
        end
        if (byte_vld && byte_rdy) begin
            acc++;
            gap = int'($urandom_range(0, max_gap));
        end
    endtask

    task automatic run_frame(input int len_req, input bit sl, input int hold_idx, input int max_gap,
                             input int abort_at, output int total);
        int n, sent, acc, gap, c, ld;
        bit urun, ok, rdy_e;
        total = 0;
        n     = (len_req > MAXB) ? MAXB : len_req;
        urun  = (hold_idx >= 0) && (hold_idx < n);
        sent  = urun ? hold_idx : n;
        build_exp(sent, urun, sl);
        acc = 0;
        gap = 0;
        @(negedge clk);
        chk("pre_idle", obs_vec(), IDLE_V, ok);
        if (!ok) begin do_reset(); return; end
        len = LW'(len_req); stop_long = sl; start = 1'b1;
        c = 0;
        while (acc == 0) begin
            @(negedge clk);
            start = 1'b0;
            c++;
            chk("fetch", obs_vec(), FETCH_V, ok);
            if (ok && c > 100) chk("fetch_hs_timeout", 32'(acc), 32'd1, ok);
            if (!ok) begin do_reset(); return; end
            drive(n, 1'b1, max_gap, acc, gap);
        end
        for (int t = 0; t < exp_q.size(); t++) begin
            @(negedge clk);
            ld = t / BYTE_CYC + 1;
            if (ld > sent) ld = sent;
            rdy_e = (t < data_end) && (acc == ld) && (acc < n);
            chk($sformatf("line t=%0d", t), obs_vec(), {26'b0, exp_q[t], rdy_e}, ok);
            if (!ok) begin do_reset(); return; end
            if (t == abort_at) begin
                rst = 1'b1; start = 1'b0; byte_vld = 1'b0;
                @(negedge clk);
                chk("rst_mid", obs_vec(), IDLE_V, ok);
                rst = 1'b0;
                return;
            end
            // Starts while busy (and in the done cycle) must be ignored; stop_long change tests capture.
            if (t == exp_q.size() / 2) begin
                start = 1'b1; len = LW'($urandom_range(0, 7)); stop_long = ~sl;
            end else if (t == exp_q.size() - 1 && !urun) begin
                start = 1'b1; len = LW'(1);
            end else begin
                start = 1'b0;
            end
            drive(n, (acc != hold_idx) || (t >= data_end), max_gap, acc, gap);
        end
        total = c + 1 + exp_q.size();
        @(negedge clk);
        start = 1'b0; byte_vld = 1'b0;
        chk("post_idle", obs_vec(), IDLE_V, ok);
        if (!ok) do_reset();
    endtask

    initial begin
        bit ok;
        int total;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_state", obs_vec(), IDLE_V, ok);
        rst = 1'b0;

        fbytes = '{8'h80, 8'h00, 8'h00, 8'h00};
        run_frame(1, 1'b0, -1, 0, -1, total);
        chk("t1_total_cycles", 32'(total), T1_TOTAL, ok);

        fbytes = '{8'hA5, 8'h0F, 8'hFF, 8'h00};
        run_frame(3, 1'b1, -1, 0, -1, total);

        fbytes = '{8'(($urandom)), 8'h3C, 8'h00, 8'h00};
        run_frame(2, 1'b0, 1, 0, -1, total);

        for (int k = 0; k < MAXB; k++) fbytes[k] = 8'($urandom);
        run_frame(4, 1'b0, -1, 0, 3 * 4 * Q + 2 * Q, total);
        run_frame(4, 1'b1, -1, 3, -1, total);

        @(negedge clk);
        len = '0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) begin
            chk("len0_idle", obs_vec(), IDLE_V, ok);
            @(negedge clk);
        end

        fbytes = '{8'h01, 8'h00, 8'h00, 8'h00};
        run_frame(1, 1'b0, -1, 0, -1, total);

        for (int k = 0; k < MAXB; k++) fbytes[k] = 8'($urandom);
        run_frame(7, 1'b1, -1, 5, -1, total);

        for (int f = 0; f < 3; f++) begin
            for (int k = 0; k < MAXB; k++) fbytes[k] = 8'($urandom);
            run_frame(int'($urandom_range(1, 7)), 1'($urandom_range(0, 1)), -1, 20, -1, total);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/joybus_tx_frame.md
Name: joybus_tx_frame

Overview:
Parametrised Joybus line transmitter. Serialises a variable-length frame of 1..MAX_BYTES bytes, fed through a byte handshake with a one-byte holding buffer, into Joybus bit cells followed by a selectable console-style or controller-style stop bit. It is the successor to the fixed single-byte console transmitter and sits between the command/response engine and the bidirectional data-pin driver. It pairs with the Joybus receiver on the same pin.

Parameters:
QUART_CYC, 50, clk cycles per quarter bit cell (1 us at 50 MHz); legal range 2 or more.
MAX_BYTES, 36, maximum payload bytes per frame.
STOP_HOLD_CYC, 100, cycles the line is released after the stop low phase, before done.
LEN_W, $clog2(MAX_BYTES+1), width of len.

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
start  in  1  frame request; sampled only in IDLE
len  in  LEN_W  payload byte count, captured with start
stop_long  in  1  captured with start; 0 = 1-quarter stop low (console), 1 = 2-quarter stop low (controller)
byte_data  in  8  payload byte, MSB sent first
byte_vld  in  1  byte_data valid
byte_rdy  out  1  holding buffer can accept a byte
jb_tx  out  1  line value to drive (1 = high)
jb_oe  out  1  pin output enable; 1 while the frame drives the line
busy  out  1  high from start acceptance until return to IDLE
done  out  1  one-cycle pulse on normal frame completion
underrun  out  1  one-cycle pulse on abort because a byte was late

Behaviour:
- Reset: state IDLE, jb_tx=1, jb_oe=0, byte_rdy=0, busy=0, done=0, underrun=0. Holding buffer emptied. Byte and bit counters cleared. All outputs are registered.
- Reset mid-frame: outputs take reset values on the next edge. The partial frame is discarded with no done or underrun pulse.
- States: IDLE, FETCH, BIT, STOP_LOW, STOP_HOLD.
- IDLE:
  - start=1 with len!=0: capture len and stop_long, set busy, go to FETCH.
  - start with len==0: ignored.
  - start while busy: ignored.
- FETCH: byte_rdy=1. A handshake (byte_vld & byte_rdy) at cycle A loads the shift register. At A+1 the state is BIT, jb_oe=1 and jb_tx=0. FETCH has no timeout.
- Bit cell: exactly 4*QUART_CYC cycles.
  - Quarter 0: low.
  - Quarters 1 and 2: the data bit.
  - Quarter 3: high.
  - Result: bit 1 = QUART_CYC low then 3*QUART_CYC high; bit 0 = 3*QUART_CYC low then QUART_CYC high.
- Holding buffer:
  - byte_rdy=1 in BIT when the buffer is empty and bytes not yet fetched exceed 0.
  - A handshake fills the buffer on that edge, and byte_rdy drops on the next cycle.
- Byte boundary (last cycle of bit 7):
  - More bytes remain and the buffer is full: move the buffer into the shift register and continue with no gap.
  - More bytes remain and the buffer is empty: pulse underrun, set jb_oe=0, jb_tx=1, busy=0, go to IDLE, no done.
  - No bytes remain: go to STOP_LOW.
- STOP_LOW: jb_oe=1, jb_tx=0 for QUART_CYC cycles (stop_long=0) or 2*QUART_CYC cycles (stop_long=1).
- STOP_HOLD: jb_oe=0, jb_tx=1 for STOP_HOLD_CYC cycles. On its last cycle, done pulses for 1 cycle with busy=0 the same cycle, then IDLE. A start presented in that cycle is ignored.
- Byte counters are LEN_W wide. A len greater than MAX_BYTES is clamped to MAX_BYTES.
- The cycle counter is sized for max(2*QUART_CYC, STOP_HOLD_CYC). It reloads at each phase boundary with no off-by-one: every phase lasts exactly its stated cycle count.

Optional Feature:
JBTX_CRC_EN:
- Defined: after the last payload byte, one extra byte is sent before the stop bit. It is the CRC-8 of the payload: poly 0x85, init 0x00, MSB-first, no reflection, no final XOR. The CRC is computed as bytes enter the shift register and needs no extra handshake. len still counts payload bytes only.
- Undefined: no CRC logic, and the stop bit follows the last payload byte directly.

Test Plan (QUART_CYC=50, STOP_HOLD_CYC=100):
1. start, len=1, stop_long=0, byte 0x80 offered immediately -> jb_tx: 50 low/150 high, then 7x(150 low/50 high), then 50 low, then 100 released; done pulses once; total busy = 1+1+1600+150 cycles ±0.
2. len=3, stop_long=1, bytes 0xA5, 0x0F, 0xFF, each offered when byte_rdy rises -> 24 contiguous cells with no inter-byte gap; stop low 100 cycles; byte_rdy never high while the buffer is full.
3. len=2, second byte withheld until after byte 1 ends -> underrun pulses at the end of bit 7 of byte 1; jb_oe=0 the next cycle; no done; IDLE accepts a new start.
4. rst asserted mid-bit 3 of a 4-byte frame -> next edge: jb_oe=0, jb_tx=1, busy=0, byte_rdy=0; new frame then runs correctly.
5. start with len=0, and start while busy -> no state change, no byte_rdy, no pulses.
6. JBTX_CRC_EN defined, len=1, byte 0x01 -> 16 data cells: 0x01 then 0x85, then stop; done once.
